// File: rtl/rcn_master.sv
// rcn_master: lets one local client inject requests onto the rcn ring
// and consume the responses that carry its own ring ID.
module rcn_master #(
  parameter logic [5:0] MASTER_ID = 6'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [66:0] rcn_in,
  output logic [66:0] rcn_out,
  input  logic        cs,
  output logic        busy,
  input  logic        wr,
  input  logic [3:0]  mask,
  input  logic [21:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic        rsp_wr,
  output logic [1:0]  rsp_seq,
  output logic [31:0] rsp_data,
  output logic [1:0]  seq_out,
  output logic        unexpected
);

  logic [66:0] rin;
  logic [66:0] rout;
  logic [3:0]  pend;
  logic [1:0]  next_seq;
  logic [1:0]  rseq;
  logic        my_rsp;
  logic        slot_free;
  logic        accept;
  logic        rsp_known;
  logic        unused_addr;

  assign rseq      = rin[57:56];
  assign my_rsp    = rin[66] && !rin[65] && (rin[63:58] == MASTER_ID);
  assign slot_free = !rin[66] || my_rsp;
  // pend is checked before any same-cycle clear
  assign busy      = !slot_free || pend[next_seq];
  assign accept    = cs && !busy;
  assign rsp_known = pend[rseq];
  assign seq_out   = next_seq;
  assign rcn_out   = rout;

  assign unused_addr = ^addr[1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      rin        <= '0;
      rout       <= '0;
      pend       <= '0;
      next_seq   <= '0;
      rsp_valid  <= 1'b0;
      rsp_wr     <= 1'b0;
      rsp_seq    <= '0;
      rsp_data   <= '0;
      unexpected <= 1'b0;
    end else begin
      rin        <= rcn_in;
      rsp_valid  <= 1'b0;
      unexpected <= 1'b0;

      if (accept) begin
        rout <= {1'b1, 1'b1, wr, MASTER_ID, next_seq, mask,
                 addr[21:2], wr ? wdata : 32'd0};
        pend[next_seq] <= 1'b1;
        next_seq       <= next_seq + 2'd1;
      end else if (my_rsp) begin
        rout <= '0;
      end else begin
        rout <= rin;
      end

      if (my_rsp) begin
        if (rsp_known) begin
          pend[rseq] <= 1'b0;
          rsp_valid  <= 1'b1;
          rsp_wr     <= rin[64];
          rsp_seq    <= rseq;
          rsp_data   <= rin[31:0];
        end else begin
          unexpected <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rcn_master.sv
// tb_rcn_master: directed stimulus, per-cycle transaction-model compare,
// plus literal expectations for the documented scenarios.
module tb_rcn_master;

  localparam logic [5:0] MID = 6'd1;

  logic        clk = 1'b0;
  logic        rst;
  logic [66:0] rcn_in;
  logic [66:0] rcn_out;
  logic        cs;
  logic        busy;
  logic        wr;
  logic [3:0]  mask;
  logic [21:0] addr;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic        rsp_wr;
  logic [1:0]  rsp_seq;
  logic [31:0] rsp_data;
  logic [1:0]  seq_out;
  logic        unexpected;

  int checks = 0;
  int errors = 0;

  rcn_master #(.MASTER_ID(MID)) dut (
    .clk(clk), .rst(rst), .rcn_in(rcn_in), .rcn_out(rcn_out),
    .cs(cs), .busy(busy), .wr(wr), .mask(mask), .addr(addr),
    .wdata(wdata), .rsp_valid(rsp_valid), .rsp_wr(rsp_wr),
    .rsp_seq(rsp_seq), .rsp_data(rsp_data), .seq_out(seq_out),
    .unexpected(unexpected)
  );

  always #5 clk = ~clk;

  function automatic logic [66:0] pkt(input bit v, input bit p,
      input bit w, input logic [5:0] id, input logic [1:0] s,
      input logic [3:0] m, input logic [19:0] a,
      input logic [31:0] d);
    return {v, p, w, id, s, m, a, d};
  endfunction

  task automatic chk(input string n, input logic [66:0] a,
                     input logic [66:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask

  // Transaction model: ring slot seen by the node, outstanding
  // seq set, and a running count of issued requests.
  logic [66:0] m_slot = '0;
  logic [66:0] m_out = '0;
  bit          m_out_seq[4];
  int          m_issued = 0;
  bit          m_rv = 0, m_unx = 0, m_rwr = 0;
  logic [1:0]  m_rseq = '0;
  logic [31:0] m_rdata = '0;

  function automatic bit is_own_rsp(input logic [66:0] w);
    return w[66] && !w[65] && w[63:58] == MID;
  endfunction

  function automatic bit m_busy();
    bit taken;
    taken = w_taken(m_slot);
    return taken || m_out_seq[m_issued % 4];
  endfunction

  function automatic bit w_taken(input logic [66:0] w);
    return w[66] && !is_own_rsp(w);
  endfunction

  always @(posedge clk) begin
    bit own, take;
    int s, ns;
    if (!rst) begin
      m_slot = '0; m_out = '0; m_issued = 0;
      foreach (m_out_seq[i]) m_out_seq[i] = 0;
      m_rv = 0; m_unx = 0; m_rwr = 0; m_rseq = '0; m_rdata = '0;
    end else begin
      own  = is_own_rsp(m_slot);
      ns   = m_issued % 4;
      take = cs && !m_busy();
      m_rv = 0;
      m_unx = 0;
      if (own) begin
        s = int'(m_slot[57:56]);
        if (m_out_seq[s]) begin
          m_out_seq[s] = 0;
          m_rv = 1; m_rwr = m_slot[64];
          m_rseq = m_slot[57:56]; m_rdata = m_slot[31:0];
        end else begin
          m_unx = 1;
        end
      end
      if (take) begin
        m_out = pkt(1, 1, wr, MID, 2'(ns), mask, addr[21:2],
                    wr ? wdata : 32'd0);
        m_out_seq[ns] = 1;
        m_issued++;
      end else begin
        m_out = own ? 67'd0 : m_slot;
      end
      m_slot = rcn_in;
    end
  end

  always @(negedge clk) begin
    chk("m_rcn_out", rcn_out, m_out);
    chk("m_busy", 67'(busy), 67'(m_busy()));
    chk("m_seq_out", 67'(seq_out), 67'(m_issued % 4));
    chk("m_rsp_valid", 67'(rsp_valid), 67'(m_rv));
    chk("m_unexpected", 67'(unexpected), 67'(m_unx));
    chk("m_rsp_wr", 67'(rsp_wr), 67'(m_rwr));
    chk("m_rsp_seq", 67'(rsp_seq), 67'(m_rseq));
    chk("m_rsp_data", 67'(rsp_data), 67'(m_rdata));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [66:0] f_req, f_rsp, own_req;

  initial begin
    rst = 1'b0; cs = 1'b0; wr = 1'b0; mask = '0; addr = '0;
    wdata = '0; rcn_in = '0;
    tick(); tick();
    chk("reset_out", rcn_out, 67'd0);
    chk("reset_busy", 67'(busy), 67'd0);
    chk("reset_seq", 67'(seq_out), 67'd0);
    rst = 1'b1;

    // foreign traffic and own-ID requests pass through untouched
    f_req   = pkt(1, 1, 0, 6'd5, 2'd0, 4'hF, 20'h00010, 32'd0);
    f_rsp   = pkt(1, 0, 1, 6'd5, 2'd2, 4'hF, 20'h00123, 32'hCAFE);
    own_req = pkt(1, 1, 0, 6'd1, 2'd1, 4'h3, 20'h00456, 32'd0);
    rcn_in = f_req;
    tick();
    chk("pass_busy", 67'(busy), 67'd1);
    rcn_in = '0;
    tick();
    chk("pass_req", rcn_out, f_req);
    rcn_in = f_rsp;
    tick();
    rcn_in = own_req;
    tick();
    chk("pass_rsp", rcn_out, f_rsp);
    rcn_in = '0;
    tick();
    chk("pass_own_req", rcn_out, own_req);

    // write then its response
    cs = 1'b1; wr = 1'b1; addr = 22'h000040;
    wdata = 32'hDEADBEEF; mask = 4'hF;
    tick();
    cs = 1'b0;
    chk("wr_out", rcn_out,
        pkt(1, 1, 1, 6'd1, 2'd0, 4'hF, 20'h00010, 32'hDEADBEEF));
    chk("wr_seq", 67'(seq_out), 67'd1);
    rcn_in = pkt(1, 0, 1, 6'd1, 2'd0, 4'h0, 20'h0, 32'h0);
    tick();
    rcn_in = '0;
    tick();
    chk("wr_rsp_valid", 67'(rsp_valid), 67'd1);
    chk("wr_rsp_seq", 67'(rsp_seq), 67'd0);
    chk("wr_rsp_wr", 67'(rsp_wr), 67'd1);
    chk("wr_consumed", rcn_out, 67'd0);
    tick();
    chk("wr_pulse_end", 67'(rsp_valid), 67'd0);

    // four outstanding, out-of-order return
    rst = 1'b0;
    tick();
    rst = 1'b1;
    wr = 1'b0; mask = 4'h3;
    for (int i = 0; i < 4; i++) begin
      cs = 1'b1; addr = 22'h000100 + 22'(i * 4);
      tick();
    end
    chk("four_busy", 67'(busy), 67'd1);
    chk("four_seq", 67'(seq_out), 67'd0);
    tick();
    cs = 1'b0;
    chk("fifth_blocked", rcn_out, 67'd0);
    rcn_in = pkt(1, 0, 0, 6'd1, 2'd2, 4'h0, 20'h0, 32'h22222222);
    tick();
    rcn_in = '0;
    chk("ret2_busy", 67'(busy), 67'd1);
    tick();
    chk("ret2_valid", 67'(rsp_valid), 67'd1);
    chk("ret2_seq", 67'(rsp_seq), 67'd2);
    chk("ret2_data", 67'(rsp_data), 67'h22222222);
    chk("ret2_still_busy", 67'(busy), 67'd1);
    rcn_in = pkt(1, 0, 0, 6'd1, 2'd0, 4'h0, 20'h0, 32'h00000A0A);
    tick();
    rcn_in = '0;
    chk("ret0_busy_pre", 67'(busy), 67'd1);
    tick();
    chk("ret0_seq", 67'(rsp_seq), 67'd0);
    chk("ret0_valid", 67'(rsp_valid), 67'd1);
    chk("ret0_free", 67'(busy), 67'd0);

    // consume seq 1 and inject seq 3 in the same slot
    rst = 1'b0;
    tick();
    rst = 1'b1;
    mask = 4'hF;
    for (int i = 0; i < 3; i++) begin
      cs = 1'b1; addr = 22'h000200 + 22'(i * 4);
      tick();
    end
    cs = 1'b0;
    chk("ci_seq", 67'(seq_out), 67'd3);
    rcn_in = pkt(1, 0, 0, 6'd1, 2'd1, 4'h0, 20'h0, 32'h11111111);
    tick();
    rcn_in = '0;
    cs = 1'b1; wr = 1'b1; addr = 22'h3FFFFC;
    wdata = 32'h12345678; mask = 4'h5;
    chk("ci_busy", 67'(busy), 67'd0);
    tick();
    cs = 1'b0; wr = 1'b0;
    chk("ci_out", rcn_out,
        pkt(1, 1, 1, 6'd1, 2'd3, 4'h5, 20'hFFFFF, 32'h12345678));
    chk("ci_valid", 67'(rsp_valid), 67'd1);
    chk("ci_rseq", 67'(rsp_seq), 67'd1);
    chk("ci_seq_wrap", 67'(seq_out), 67'd0);

    // unexpected own-ID response
    rst = 1'b0;
    tick();
    rst = 1'b1;
    rcn_in = pkt(1, 0, 0, 6'd1, 2'd3, 4'h0, 20'h0, 32'h5);
    tick();
    rcn_in = '0;
    tick();
    chk("unx_pulse", 67'(unexpected), 67'd1);
    chk("unx_no_valid", 67'(rsp_valid), 67'd0);
    chk("unx_emptied", rcn_out, 67'd0);
    tick();
    chk("unx_pulse_end", 67'(unexpected), 67'd0);

    // reset with two outstanding
    cs = 1'b1; mask = 4'h1; addr = 22'h000300;
    tick(); tick();
    cs = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mid_out", rcn_out, 67'd0);
    chk("mid_seq", 67'(seq_out), 67'd0);
    chk("mid_busy", 67'(busy), 67'd0);
    rcn_in = pkt(1, 0, 0, 6'd1, 2'd0, 4'h0, 20'h0, 32'h77);
    tick();
    rcn_in = '0;
    tick();
    chk("mid_late_unx", 67'(unexpected), 67'd1);
    chk("mid_late_valid", 67'(rsp_valid), 67'd0);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rcn_master.md
# rcn_master

Ring node that lets one local client issue read/write requests onto the rcn ring and collect the matching responses. It sits on the main ring next to `rcn_bridge` stages. It feeds requests into the ring, which a bridge or slave downstream consumes. It removes responses tagged with its own ID and passes all other ring traffic through unchanged. It tracks up to four outstanding transactions using the 2-bit seq field.

## Interface
- `MASTER_ID`, default 6'd1: ring ID placed on injected requests; responses carrying this ID are consumed.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-low (asserted when 0).
- `rcn_in`  in  67  ring input: `{valid[66], pending[65], wr[64], id[63:58], seq[57:56], mask[55:52], addr[51:32], data[31:0]}`.
- `rcn_out`  out  67  ring output, same format; registered.
- `cs`  in  1  client request strobe.
- `busy`  out  1  combinational; when 1, the client request is not accepted this cycle.
- `wr`  in  1  1 = write, 0 = read.
- `mask`  in  4  byte enables.
- `addr`  in  22  byte address; bits [21:2] go onto the ring, [1:0] are ignored.
- `wdata`  in  32  write data.
- `rsp_valid`  out  1  one-cycle pulse: a response has been delivered.
- `rsp_wr`  out  1  wr bit of the delivered response.
- `rsp_seq`  out  2  seq of the delivered response.
- `rsp_data`  out  32  data of the delivered response.
- `seq_out`  out  2  seq that will be assigned to the request accepted this cycle.
- `unexpected`  out  1  one-cycle pulse: an own-ID response arrived whose seq was not outstanding.

## Operation
- **Input register.** `rin <= rcn_in` every cycle. All decoding uses `rin`.
- **Decode on `rin`.**
  - `my_rsp = rin[66] && !rin[65] && rin[63:58]==MASTER_ID`.
  - `slot_free = !rin[66] || my_rsp`.
- **State.**
  - `next_seq` is 2 bits.
  - `pend[3:0]` has one bit per seq.
  - `seq_out = next_seq`.
- **Busy and accept.**
  - `busy = !slot_free || pend[next_seq]`.
  - A request is accepted when `cs && !busy`.
- **On accept:**
  - `rout <= {1,1,wr,MASTER_ID,next_seq,mask,addr[21:2],wr?wdata:32'd0}`.
  - Set `pend[next_seq]`.
  - `next_seq <= next_seq+1` (wraps 3 to 0).
- **Else if `my_rsp`:** `rout <= 67'd0`; the consumed slot is emptied.
- **Else:** `rout <= rin`. This passes requests from other nodes, responses for other IDs, own-ID requests, and empty slots.
- **On `my_rsp`:**
  - If `pend[rin[57:56]]` is set: clear it and register `rsp_valid<=1`, `rsp_wr<=rin[64]`, `rsp_seq<=rin[57:56]`, `rsp_data<=rin[31:0]`.
  - If that bit is clear: `unexpected<=1`, `rsp_valid` stays 0, and the slot is still consumed.
- **Simultaneous consume and inject.**
  - Both are allowed in the same cycle; the freed slot carries the new request.
  - `busy` uses `pend` before the clear. If the consumed seq equals `next_seq`, the inject is blocked that cycle and accepted the next cycle.
- **Outstanding limit.** At most 4 outstanding. Responses may return in any order; the `pend` bitmap handles this.

## Timing
- **Reset.** When `rst==0` at a clock edge, all of the following clear to 0: `rin`, `rout` (so `rcn_out`), `pend`, `next_seq`, `rsp_valid`, `rsp_wr`, `rsp_seq`, `rsp_data`, `unexpected`.
  - Reset mid-operation discards all outstanding state.
  - Responses that arrive later for pre-reset requests pulse `unexpected`.
- **Pass-through latency:** 2 cycles, from `rcn_in` at edge t to `rcn_out` after edge t+1.
- **Injection latency:** a request accepted in cycle t appears on `rcn_out` after edge t.
- **Response latency:** an own-ID response on `rcn_in` at edge t is consumed in cycle t+1, and `rsp_valid` is high in cycle t+2.
- **`busy` combinational path:** `busy` depends only on registered state (`rin`, `pend`, `next_seq`), with no combinational path from `cs`.
- **Pulse width:** `rsp_valid` and `unexpected` are high exactly one cycle per event.

## Test plan
- **Idle pass-through.** `MASTER_ID`=1; drive foreign request `{1,1,0,6'd5,2'd0,4'hF,20'h00010,32'd0}` -> identical vector on `rcn_out` 2 cycles later; `busy`=1 while it occupies `rin`.
- **Write and read.** Write `addr`=22'h000040, `wdata`=32'hDEADBEEF, `mask`=F on an empty ring -> `rcn_out`=`{1,1,1,6'd1,2'd0,4'hF,20'h00010,32'hDEADBEEF}`, `seq_out` advances to 1. Then return response `{1,0,1,6'd1,2'd0,…,32'h0}` -> `rsp_valid` pulse with `rsp_seq`=0, and `rcn_out` slot = 67'd0.
- **Four outstanding.** Issue 4 reads with no responses -> the 5th `cs` sees `busy`=1. Return seq 2 then seq 0 -> `busy` drops only when seq 0 (= `next_seq`) returns. `rsp_seq` pulses 2, then 0.
- **Consume and inject same cycle.** Own response for seq 1 arrives while `cs`=1 and `next_seq`=3 -> the request is injected into the freed slot, `rsp_valid`=1 for seq 1, and no pass-through of the response.
- **Unexpected response.** Own-ID response with seq 3 while `pend`=0 -> `unexpected` one-cycle pulse, `rsp_valid`=0, slot emptied.
- **Reset mid-operation.** `rst`=0 for one edge with 2 outstanding -> all outputs 0 and `pend`=0. A later response for seq 0 -> `unexpected`.
